// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream synchronous FIFO and sends
// them as 8N1 frames, optionally with an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for en and a non-empty FIFO
// FETCH  | pop strobe to the FIFO
// LOAD   | FIFO read data captured into the shift register, parity computed
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even-parity bit (only when PARITY_EN)
// STOP   | stop bit (high), frame_done on its last cycle
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  // Holds off the first IDLE qualification until one edge after reset release.
  logic             armed_q;
  logic             bit_end;
  logic             timed;

  assign bit_end = (cnt_q == CNT_MAX);
  assign timed   = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    case (state_q)
      S_IDLE: begin
        if (armed_q && en && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_idx_d = 3'd0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!timed || bit_end || (state_d != state_q)) cnt_d = '0;
    else                                            cnt_d = cnt_q + CNT_W'(1);

    // tx is registered, so it is derived from where the FSM is going next.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      armed_q   <= 1'b1;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = (state_q == S_FETCH);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && bit_end;

endmodule
